// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared types and constants for the 64-bit adder BIST engine
//   state_t      - controller states (IDLE, LOAD, CHECK, DONE)
//   vec_t        - one test vector {a, b, c_in}
//   LFSR_TAPS    - Galois feedback mask for x^64+x^63+x^61+x^60+1
//   FAIL_NONE    - first_fail value meaning "no failing vector"
//   directed_vec - the four directed vectors by index
package adder_bist_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      CHECK = ST_CHECK,
      DONE  = ST_DONE
   } state_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        c_in;
   } vec_t;

   // Right-shifting Galois form: taps 64,63,61,60 land on bits 63,62,60,59.
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
   localparam logic [7:0]  FAIL_NONE = 8'hFF;
   localparam int          N_DIRECTED = 4;

   localparam vec_t DIR_0 = '{a: 64'd3, b: 64'd5, c_in: 1'b0};
   localparam vec_t DIR_1 = '{a: 64'd3, b: 64'd5, c_in: 1'b1};
   localparam vec_t DIR_2 = '{a: '1, b: '1, c_in: 1'b1};
   localparam vec_t DIR_3 = '{a: 64'd0, b: 64'd0, c_in: 1'b0};

   function automatic vec_t directed_vec(input logic [1:0] i);
      return (i == 2'd0) ? DIR_0 :
             (i == 2'd1) ? DIR_1 :
             (i == 2'd2) ? DIR_2 : DIR_3;
   endfunction

endpackage

// File: rtl/lfsr64_step.sv
// lfsr64_step: one combinational step of the 64-bit Galois LFSR
//   state - current LFSR value
//   next  - value after one shift
module lfsr64_step
   import adder_bist_pkg::*;
(
   input  logic [63:0] state,
   output logic [63:0] next
);

   assign next = (state >> 1) ^ (state[0] ? LFSR_TAPS : 64'd0);

endmodule

// File: rtl/adder_bist_64.sv
// adder_bist_64: self-checking BIST engine for an external 64-bit adder
//   clk, rst               - clock, async active-high reset
//   start                  - begin a run (honoured in IDLE/DONE only)
//   a_o, b_o, c_in_o       - operands driven to the adder under test
//   sum_i, c_out_i         - adder result sampled back
//   busy, done, pass       - run status; pass valid while done
//   err_count, first_fail  - mismatch count (saturating) and first failing index
//   vec_idx                - index of the current vector
module adder_bist_64
   import adder_bist_pkg::*;
#(
   parameter int          N_RANDOM  = 12,
   parameter logic [63:0] LFSR_SEED = 64'hACE1_0000_0000_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [63:0] a_o,
   output logic [63:0] b_o,
   output logic        c_in_o,
   input  logic [63:0] sum_i,
   input  logic        c_out_i,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  err_count,
   output logic [7:0]  first_fail,
   output logic [7:0]  vec_idx
);

   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [63:0] SEED     = (LFSR_SEED == 64'd0) ? 64'd1 : LFSR_SEED;
   localparam logic [7:0]  LAST_IDX = 8'(N_DIRECTED + N_RANDOM - 1);

   state_t      state;
   logic [63:0] lfsr;
   logic [63:0] step1;
   logic [63:0] step2;
   logic [64:0] golden;
   logic        mismatch;
   logic        is_random;
   vec_t        dvec;

   // Two steps per random vector: step1 feeds a, step2 feeds b and c_in.
   lfsr64_step u_step1 (.state(lfsr),  .next(step1));
   lfsr64_step u_step2 (.state(step1), .next(step2));

   assign golden    = {1'b0, a_o} + {1'b0, b_o} + {64'd0, c_in_o};
   assign mismatch  = golden != {c_out_i, sum_i};
   assign is_random = vec_idx >= 8'(N_DIRECTED);
   assign dvec      = directed_vec(vec_idx[1:0]);

   assign busy = (state == LOAD) || (state == CHECK);
   assign done = state == DONE;
   assign pass = done && (err_count == 8'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= SEED;
         a_o        <= 64'd0;
         b_o        <= 64'd0;
         c_in_o     <= 1'b0;
         err_count  <= 8'd0;
         first_fail <= FAIL_NONE;
         vec_idx    <= 8'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= LOAD;
                  lfsr       <= SEED;
                  err_count  <= 8'd0;
                  first_fail <= FAIL_NONE;
                  vec_idx    <= 8'd0;
               end
            end
            LOAD: begin
               a_o    <= is_random ? step1    : dvec.a;
               b_o    <= is_random ? step2    : dvec.b;
               c_in_o <= is_random ? step2[0] : dvec.c_in;
               lfsr   <= is_random ? step2    : lfsr;
               state  <= CHECK;
            end
            default: begin
               if (mismatch) begin
                  err_count  <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                  first_fail <= (first_fail == FAIL_NONE) ? vec_idx : first_fail;
               end
               state   <= (vec_idx == LAST_IDX) ? DONE : LOAD;
               vec_idx <= (vec_idx == LAST_IDX) ? vec_idx : vec_idx + 8'd1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_bist_64.sv
// tb_adder_bist_64: table-driven and randomized checks of adder_bist_64 against a vector/fault model
module tb_adder_bist_64;

   localparam int V0 = 16;
   localparam int V1 = 255;
   localparam logic [64:0] POLY = 65'h1_B000_0000_0000_0001;

   logic clk = 1'b0;
   logic rst, start, start1;

   logic [63:0] a0, b0, sum0, a1, b1, sum1;
   logic        c0, cout0, busy0, done0, pass0;
   logic        c1, cout1, busy1, done1, pass1;
   logic [7:0]  err0, ff0, idx0, err1, ff1, idx1;

   int          fault;
   logic [63:0] fmask;

   logic [63:0] ma [V1];
   logic [63:0] mb [V1];
   logic        mc [V1];

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   // Adder under test with optional injected faults.
   function automatic logic [64:0] adder(input int mode, input logic [63:0] m,
                                         input logic [63:0] a, input logic [63:0] b, input logic c);
      logic [64:0] g;
      g = {1'b0, a} + {1'b0, b} + {64'd0, c};
      case (mode)
         1:       return {g[64], g[63:1], 1'b0};
         2:       return {1'b0, g[63:0]};
         3:       return {g[64], ~g[63:0]};
         4:       return c ? {g[64], g[63:0] ^ m} : g;
         default: return g;
      endcase
   endfunction

   assign {cout0, sum0} = adder(fault, fmask, a0, b0, c0);
   assign {cout1, sum1} = adder(3, 64'd0, a1, b1, c1);

   adder_bist_64 #(.N_RANDOM(12)) dut0 (
      .clk(clk), .rst(rst), .start(start),
      .a_o(a0), .b_o(b0), .c_in_o(c0), .sum_i(sum0), .c_out_i(cout0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .first_fail(ff0), .vec_idx(idx0)
   );

   adder_bist_64 #(.N_RANDOM(251)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .a_o(a1), .b_o(b1), .c_in_o(c1), .sum_i(sum1), .c_out_i(cout1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail(ff1), .vec_idx(idx1)
   );

   // LFSR step defined as polynomial reduction: fold P in when the low bit is set, then divide by x.
   function automatic logic [63:0] gstep(input logic [63:0] s);
      logic [64:0] r;
      r = {1'b0, s};
      if (s[0]) r = r ^ POLY;
      return r[64:1];
   endfunction

   task automatic gen_vectors();
      logic [63:0] s, s1, s2;
      ma[0] = 64'd3; mb[0] = 64'd5; mc[0] = 1'b0;
      ma[1] = 64'd3; mb[1] = 64'd5; mc[1] = 1'b1;
      ma[2] = '1;    mb[2] = '1;    mc[2] = 1'b1;
      ma[3] = 64'd0; mb[3] = 64'd0; mc[3] = 1'b0;
      s = 64'hACE1_0000_0000_BEEF;
      for (int i = 4; i < V1; i++) begin
         s1 = gstep(s);
         s2 = gstep(s1);
         ma[i] = s1; mb[i] = s2; mc[i] = s2[0];
         s = s2;
      end
   endtask

   task automatic expect_run(input int mode, input logic [63:0] m, input int nv,
                             output int e, output logic [7:0] f);
      logic [64:0] g;
      e = 0;
      f = 8'hFF;
      for (int i = 0; i < nv; i++) begin
         g = {1'b0, ma[i]} + {1'b0, mb[i]} + {64'd0, mc[i]};
         if (adder(mode, m, ma[i], mb[i], mc[i]) != g) begin
            if (e < 255) e++;
            if (f == 8'hFF) f = 8'(i);
         end
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_a", a0, 64'd0);
      check("rst_b", b0, 64'd0);
      check("rst_cin", {63'd0, c0}, 64'd0);
      check("rst_busy", {63'd0, busy0}, 64'd0);
      check("rst_done", {63'd0, done0}, 64'd0);
      check("rst_pass", {63'd0, pass0}, 64'd0);
      check("rst_err", {56'd0, err0}, 64'd0);
      check("rst_ff", {56'd0, ff0}, 64'hFF);
      check("rst_idx", {56'd0, idx0}, 64'd0);
   endtask

   // Runs dut0 once; rst_at>0 aborts with an asynchronous reset, poke pulses start mid-run.
   task automatic run0(input int rst_at, input bit poke);
      int n;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("start_done_drop", {63'd0, done0}, 64'd0);
      check("start_busy", {63'd0, busy0}, 64'd1);
      n = 0;
      while (!done0 && n < 100) begin
         if (n % 2 == 1 && n < 2 * V0) begin
            check("vec_a", a0, ma[(n - 1) / 2]);
            check("vec_b", b0, mb[(n - 1) / 2]);
            check("vec_cin", {63'd0, c0}, {63'd0, mc[(n - 1) / 2]});
            check("vec_idx", {56'd0, idx0}, 64'((n - 1) / 2));
         end
         if (poke && n == 7) start = 1'b1;
         if (poke && n == 8) start = 1'b0;
         if (rst_at > 0 && n == rst_at) begin
            #2 rst = 1'b1;
            #1 check_reset_vals();
            #1 rst = 1'b0;
            return;
         end
         @(negedge clk);
         n++;
      end
      check("done_latency", 64'(n), 64'(2 * V0));
   endtask

   typedef struct {
      int          mode;
      logic [63:0] mask;
      int          idle;
      int          exp_err;
      logic [7:0]  exp_ff;
   } tv_t;

   tv_t tv [7];

   initial begin
      int e;
      logic [7:0] f;
      int n;
      rst = 1'b1; start = 1'b0; start1 = 1'b0; fault = 0; fmask = 64'd0;
      gen_vectors();
      tv[0] = '{mode: 0, mask: 64'd0, idle: 2, exp_err: 0,  exp_ff: 8'hFF};
      tv[1] = '{mode: 1, mask: 64'd0, idle: 0, exp_err: -1, exp_ff: 8'd1};
      tv[2] = '{mode: 2, mask: 64'd0, idle: 1, exp_err: -1, exp_ff: 8'd2};
      tv[3] = '{mode: 3, mask: 64'd0, idle: 0, exp_err: 16, exp_ff: 8'd0};
      tv[4] = '{mode: 4, mask: {$urandom, $urandom} | 64'd1, idle: 0, exp_err: -1, exp_ff: 8'd1};
      tv[5] = '{mode: 4, mask: {$urandom, $urandom} | 64'd1, idle: 3, exp_err: -1, exp_ff: 8'd1};
      tv[6] = '{mode: 0, mask: 64'd0, idle: 0, exp_err: 0,  exp_ff: 8'hFF};
      for (int i = 0; i < 7; i++)
         if (tv[i].exp_err < 0) begin
            expect_run(tv[i].mode, tv[i].mask, V0, e, f);
            tv[i].exp_err = e;
         end

      repeat (3) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         fault = tv[i].mode;
         fmask = tv[i].mask;
         repeat (tv[i].idle + int'($urandom_range(0, 2))) @(negedge clk);
         run0(0, 1'b0);
         check("err_count", {56'd0, err0}, 64'(tv[i].exp_err));
         check("first_fail", {56'd0, ff0}, {56'd0, tv[i].exp_ff});
         check("pass", {63'd0, pass0}, {63'd0, tv[i].exp_err == 0});
         check("final_idx", {56'd0, idx0}, 64'(V0 - 1));
         @(negedge clk);
         check("done_hold", {63'd0, done0}, 64'd1);
         check("a_hold", a0, ma[V0 - 1]);
      end

      fault = 0;
      run0(10, 1'b0);
      @(negedge clk);
      check("idle_after_rst", {63'd0, busy0}, 64'd0);
      run0(0, 1'b0);
      check("rerun_pass", {63'd0, pass0}, 64'd1);

      run0(0, 1'b1);
      check("poke_pass", {63'd0, pass0}, 64'd1);
      check("poke_ff", {56'd0, ff0}, 64'hFF);

      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      n = 0;
      while (!done1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("sat_latency", 64'(n), 64'(2 * V1));
      check("sat_err", {56'd0, err1}, 64'd255);
      check("sat_ff", {56'd0, ff1}, 64'd0);
      check("sat_pass", {63'd0, pass1}, 64'd0);
      check("sat_idx", {56'd0, idx1}, 64'(V1 - 1));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
